async_fifo_reader: RTL

Read-side adapter for the team's asynchronous FIFO. It drives the FIFO's read-enable/empty/read-data interface and turns it into a registered valid/ready stream for downstream logic in the read clock domain. It supports both FIFO read modes: registered read data (1-cycle latency) and first-word-fall-through. A 2-entry skid buffer sustains one word per cycle under continuous `i_ready` and keeps `o_data` stable under backpressure.

---
 rtl/async_fifo_pkg.sv | 23 ++
 rtl/stream_skid2.sv | 72 +++++++
 rtl/async_fifo_reader.sv | 61 ++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared types and gray-code helpers for the async FIFO and its read adapter
package async_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/stream_skid2.sv
// rtl/stream_skid2.sv - two-entry skid buffer; slot0 is the output register, slot1 absorbs one word of backpressure
module stream_skid2
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             arrive,
    input  logic [WIDTH-1:0] word,
    input  logic             pop,
    output occ_t             occ,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    occ_t             occ_next;
    logic [WIDTH-1:0] slot1;
    logic [WIDTH-1:0] slot0_next;
    logic [WIDTH-1:0] slot1_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            occ     <= EMPTY;
            o_valid <= 1'b0;
            o_data  <= '0;
            slot1   <= '0;
        end else begin
            occ     <= occ_next;
            o_valid <= (occ_next != EMPTY);
            o_data  <= slot0_next;
            slot1   <= slot1_next;
        end
    end

    // TWO with arrive and no pop cannot occur: the reader's space rule withholds the read.
    always_comb begin
        occ_next   = occ;
        slot0_next = o_data;
        slot1_next = slot1;
        case (occ)
            EMPTY: begin
                if (arrive) begin
                    slot0_next = word;
                    occ_next   = ONE;
                end
            end
            ONE: begin
                if (pop && arrive) begin
                    slot0_next = word;
                end else if (pop) begin
                    occ_next = EMPTY;
                end else if (arrive) begin
                    slot1_next = word;
                    occ_next   = TWO;
                end
            end
            TWO: begin
                if (pop) begin
                    slot0_next = slot1;
                    if (arrive) begin
                        slot1_next = word;
                    end else begin
                        occ_next = ONE;
                    end
                end
            end
            default: occ_next = EMPTY;
        endcase
    end

endmodule

// File: rtl/async_fifo_reader.sv
// rtl/async_fifo_reader.sv - read-side adapter turning FIFO ren/empty/rdata into a registered valid/ready stream
module async_fifo_reader
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter bit FWFT  = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_fifo_ren,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_rdata,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    occ_t       occ;
    logic       pop;
    logic       arrive;
    logic       inflight;
    logic [1:0] count;
    logic [2:0] space;

    assign pop   = o_valid && i_ready;
    assign count = (occ == TWO) ? 2'd2 : ((occ == ONE) ? 2'd1 : 2'd0);

    // A word already requested but not yet captured reserves a slot, so the buffer never overflows.
    assign space      = 3'd2 + {2'b00, pop} - {1'b0, count} - {2'b00, inflight};
    assign o_fifo_ren = !i_fifo_empty && (space >= 3'd1) && !i_rst;

    generate
        if (FWFT) begin : g_fwft
            assign inflight = 1'b0;
            assign arrive   = o_fifo_ren;
        end else begin : g_registered
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    inflight <= 1'b0;
                end else begin
                    inflight <= o_fifo_ren;
                end
            end
            assign arrive = inflight;
        end
    endgenerate

    stream_skid2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .arrive (arrive),
        .word   (i_fifo_rdata),
        .pop    (pop),
        .occ    (occ),
        .o_valid(o_valid),
        .o_data (o_data)
    );

endmodule
